simple_transposer: RTL and testbench
====================================

// Module: simple_transposer
// PURPOSE
//   Stream stage directly downstream of the simple register/handshake stage.
//   Collects a block of NumElems input beats into a NumElems x NumElems matrix
//   of ElemWidth-bit elements, then replays it one output beat per handshake,
//   either transposed (column order) or unchanged (row order).
//   Same valid-ready stream protocol on both sides; single buffer, no overlap
//   between filling and draining.
// PARAMETERS
//   ElemWidth  8  bits per matrix element
//   NumElems   8  elements per beat = beats per block (>=2, power of 2)
//   DataWidth  ElemWidth*NumElems  derived local parameter, beat width
// PORTS
//   clk_i           in   1          clock
//   rst_ni          in   1          reset, asynchronous, active-low
//   data_i          in   DataWidth  input beat (one matrix row)
//   data_valid_i    in   1          input beat valid
//   data_ready_o    out  1          stage accepts input beat
//   transpose_en_i  in   1          1=transpose block, 0=pass rows through; sampled on beat 0
//   data_o          out  DataWidth  output beat
//   data_valid_o    out  1          output beat valid
//   data_ready_i    in   1          downstream accepts output beat
//   busy_o          out  1          block partially filled or draining
// BEHAVIOUR
//   - Element j of a beat = bits [j*ElemWidth +: ElemWidth]; row r = r-th accepted beat.
//   - Reset (async): state=FILL, wr_cnt=0, rd_cnt=0, matrix=0, mode=0;
//     data_ready_o=1, data_valid_o=0, data_o=0, busy_o=0.
//   - FILL:
//     - data_ready_o=1, data_valid_o=0, data_o=0.
//     - Input handshake (valid&ready): store data_i in row wr_cnt.
//     - On beat 0, latch transpose_en_i as mode; later changes ignored until next block.
//     - wr_cnt++ per handshake; at wr_cnt=NumElems-1: wr_cnt wraps to 0, rd_cnt=0, go DRAIN.
//   - DRAIN:
//     - data_ready_o=0, data_valid_o=1.
//     - data_o = mode ? column rd_cnt (element r = row r elem rd_cnt) : row rd_cnt.
//     - Output handshake: rd_cnt++; at rd_cnt=NumElems-1 handshake: rd_cnt wraps to 0, go FILL.
//   - Latency: first output valid the cycle after the last input beat is accepted.
//     Block throughput = 2*NumElems cycles with no stalls.
//   - data_o and data_valid_o stay stable while data_valid_o=1 and data_ready_i=0.
//   - data_valid_i ignored in DRAIN (ready low); data_ready_i ignored in FILL.
//   - No combinational path from data_ready_i to data_ready_o, or from data_valid_i to data_valid_o.
//   - busy_o = (state==DRAIN) | (wr_cnt!=0).
//   - Input bubbles in FILL: counters hold, no buffer write.
//   - Reset mid-block: partial block discarded, all state returns to reset values.
//   - Matrix not cleared between blocks; every row is overwritten before it is read.
// TESTING
//   - Reset: assert rst_ni=0 mid-DRAIN -> immediately data_valid_o=0, data_ready_o=1, busy_o=0;
//     next block behaves normally.
//   - Transpose, NumElems=8: row r elem c = 8*r+c, transpose_en_i=1, ready_i=1 ->
//     output beat c elem r = 8*r+c; beat 0 = 0x3830282018100800;
//     data_valid_o rises one cycle after input beat 7.
//   - Passthrough: transpose_en_i=0 on beat 0, toggled to 1 on beat 3 ->
//     8 output beats identical to inputs, in order.
//   - Backpressure: data_ready_i=0 for 5 cycles on output beat 2 ->
//     data_o held constant, rd_cnt held, data_ready_o=0 throughout.
//   - Input bubbles: valid_i low every other cycle ->
//     DRAIN entered only after 8 accepted beats; busy_o=1 from beat 0.
//   - Back-to-back: 3 blocks with valid_i and ready_i always 1 ->
//     48 cycles total, ready_o/valid_o alternate in 8-cycle windows, no beat lost or duplicated.

Source files
------------

// File: rtl/simple_transposer_if.sv
// Valid-ready stream bundle shared by the input and output sides of the transposer.
interface simple_transposer_if #(
    parameter int unsigned DataWidth = 64
) ();
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/simple_transposer.sv
// Block transposer: fills a NumElems x NumElems element matrix from input beats,
// then replays it row-by-row or column-by-column on the output stream.
module simple_transposer #(
    parameter int unsigned ElemWidth = 8,
    parameter int unsigned NumElems  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    simple_transposer_if.slave    in_s,
    simple_transposer_if.master   out_m,
    input  logic                  transpose_en_i,
    output logic                  busy_o
);
    localparam int unsigned DataWidth = ElemWidth * NumElems;
    localparam int unsigned CntWidth  = $clog2(NumElems);
    localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumElems - 1);

    // state | meaning
    // FILL  | accepting input beats into matrix rows, output idle
    // DRAIN | replaying the stored block, input stalled
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                                          state_q;
    logic [CntWidth-1:0]                             wr_cnt_q;
    logic [CntWidth-1:0]                             rd_cnt_q;
    logic [NumElems-1:0][NumElems-1:0][ElemWidth-1:0] matrix_q;
    logic                                            mode_q;
    logic                                            ready_q;
    logic                                            valid_q;

    logic [NumElems-1:0][ElemWidth-1:0] col_sel;
    logic [DataWidth-1:0]               data_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            matrix_q <= '0;
            mode_q   <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    // ready_q is high throughout FILL, so valid alone marks a handshake
                    if (in_s.valid) begin
                        matrix_q[wr_cnt_q] <= in_s.data;
                        if (wr_cnt_q == '0) begin
                            mode_q <= transpose_en_i;
                        end
                        if (wr_cnt_q == LastIdx) begin
                            wr_cnt_q <= '0;
                            rd_cnt_q <= '0;
                            state_q  <= DRAIN;
                            ready_q  <= 1'b0;
                            valid_q  <= 1'b1;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + CntWidth'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_m.ready) begin
                        if (rd_cnt_q == LastIdx) begin
                            rd_cnt_q <= '0;
                            state_q  <= FILL;
                            ready_q  <= 1'b1;
                            valid_q  <= 1'b0;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + CntWidth'(1);
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mux only reads registered state, keeping ready/valid paths flop-to-port.
    always_comb begin
        col_sel = '0;
        for (int unsigned r = 0; r < NumElems; r++) begin
            col_sel[CntWidth'(r)] = matrix_q[CntWidth'(r)][rd_cnt_q];
        end
        data_sel = '0;
        if (state_q == DRAIN) begin
            data_sel = mode_q ? col_sel : matrix_q[rd_cnt_q];
        end
    end

    assign in_s.ready  = ready_q;
    assign out_m.valid = valid_q;
    assign out_m.data  = data_sel;
    assign busy_o      = (state_q == DRAIN) | (wr_cnt_q != '0);

endmodule

// File: tb/tb_simple_transposer.sv
// Self-checking bench for simple_transposer: randomized streams against a block-level reference model.
module tb_simple_transposer;
    localparam int unsigned EW = 8;
    localparam int unsigned NE = 8;
    localparam int unsigned DW = EW * NE;

    logic clk_i;
    logic rst_ni;
    logic transpose_en;
    logic busy;

    simple_transposer_if #(.DataWidth(DW)) in_if ();
    simple_transposer_if #(.DataWidth(DW)) out_if ();

    simple_transposer #(.ElemWidth(EW), .NumElems(NE)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_s           (in_if.slave),
        .out_m          (out_if.master),
        .transpose_en_i (transpose_en),
        .busy_o         (busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: rows of the block being filled, and the beats still owed downstream
    logic [DW-1:0] rows [NE];
    int            n_rows = 0;
    logic          blk_mode = 1'b0;
    logic [DW-1:0] exp_q [$];

    function automatic logic [DW-1:0] model_beat(input int c);
        logic [DW-1:0] b;
        b = '0;
        if (blk_mode) begin
            for (int r = 0; r < NE; r++) b[r*EW +: EW] = rows[r][c*EW +: EW];
        end else begin
            b = rows[c];
        end
        return b;
    endfunction

    task automatic model_push(input logic [DW-1:0] d, input logic te);
        if (n_rows == 0) blk_mode = te;
        rows[n_rows] = d;
        n_rows++;
        if (n_rows == NE) begin
            for (int c = 0; c < NE; c++) exp_q.push_back(model_beat(c));
            n_rows = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        n_rows = 0;
    endtask

    // {ready_o, valid_o, busy_o, data_o}
    function automatic logic [DW+2:0] model_vec();
        logic drain;
        drain = (exp_q.size() != 0);
        return {!drain, drain, drain || (n_rows != 0), drain ? exp_q[0] : {DW{1'b0}}};
    endfunction

    function automatic logic [DW+2:0] dut_vec();
        return {in_if.ready, out_if.valid, busy, out_if.data};
    endfunction

    // Called at a falling edge: apply inputs, advance one clock, update the model.
    task automatic drive_and_tick(input logic v, input logic [DW-1:0] d, input logic te,
                                  input logic rdy, output logic in_acc, output logic out_acc);
        in_if.valid   = v;
        in_if.data    = d;
        transpose_en  = te;
        out_if.ready  = rdy;
        in_acc  = v && in_if.ready;
        out_acc = out_if.valid && rdy;
        @(posedge clk_i);
        @(negedge clk_i);
        if (in_acc) model_push(d, te);
        if (out_acc && exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    function automatic logic [DW-1:0] rand_row();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0; transpose_en = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (dut_vec() !== {1'b1, 1'b0, 1'b0, {DW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_held: got %h want %h", dut_vec(), {1'b1, 1'b0, 1'b0, {DW{1'b0}}});
        end
        rst_ni = 1'b1;
        model_reset();
        @(negedge clk_i);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_transpose();
        logic ia, oa;
        logic [DW-1:0] row;
        for (int i = 0; i < 2*NE; i++) begin
            row = '0;
            for (int c = 0; c < NE; c++) row[c*EW +: EW] = 8'(8*i + c);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL transpose cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (i == NE - 1) begin
                n_cmp++;
                if (out_if.valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL transpose_early_valid: got %b want 0", out_if.valid);
                end
            end
            if (i == NE) begin
                n_cmp++;
                if (out_if.valid !== 1'b1 || out_if.data !== 64'h3830282018100800) begin
                    n_fail++;
                    $display("FAIL transpose_beat0: got valid %b data %h want 1 3830282018100800",
                             out_if.valid, out_if.data);
                end
            end
            drive_and_tick(i < NE, (i < NE) ? row : '0, 1'b1, 1'b1, ia, oa);
        end
    endtask

    task automatic test_passthrough();
        logic ia, oa;
        logic [DW-1:0] src [NE];
        int idx = 0;
        for (int i = 0; i < NE; i++) src[i] = rand_row();
        for (int i = 0; i < 2*NE; i++) begin
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL passthrough cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (i >= NE) begin
                n_cmp++;
                if (out_if.data !== src[i-NE]) begin
                    n_fail++;
                    $display("FAIL passthrough_beat %0d: got %h want %h", i - NE, out_if.data, src[i-NE]);
                end
            end
            drive_and_tick(idx < NE, (idx < NE) ? src[idx] : '0, (idx >= 3), 1'b1, ia, oa);
            if (ia) idx++;
        end
    endtask

    task automatic test_backpressure();
        logic ia, oa;
        logic [DW-1:0] held;
        int pops = 0;
        int stall = 0;
        int idx = 0;
        logic te;
        te = 1'($urandom);
        for (int i = 0; i < 40 && pops < NE; i++) begin
            logic rdy;
            rdy = !(pops == 2 && stall < 5);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL backpressure cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (pops == 2 && stall == 0) held = out_if.data;
            if (pops == 2 && stall > 0) begin
                n_cmp++;
                if (out_if.data !== held || in_if.ready !== 1'b0 || out_if.valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL backpressure_hold %0d: got data %h ready %b want %h 0",
                             stall, out_if.data, in_if.ready, held);
                end
            end
            drive_and_tick(idx < NE, rand_row(), te, rdy, ia, oa);
            if (ia) idx++;
            if (pops == 2 && !rdy && out_if.valid) stall++;
            if (oa) pops++;
        end
        n_cmp++;
        if (pops != NE || stall != 5) begin
            n_fail++;
            $display("FAIL backpressure_done: got pops %0d stalls %0d want %0d 5", pops, stall, NE);
        end
    endtask

    task automatic test_bubbles();
        logic ia, oa;
        int acc = 0;
        for (int i = 0; i < 3*NE; i++) begin
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL bubbles cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (acc >= 1 && acc < NE) begin
                n_cmp++;
                if (busy !== 1'b1 || out_if.valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bubbles_fill acc %0d: got busy %b valid %b want 1 0", acc, busy, out_if.valid);
                end
            end
            drive_and_tick((i % 2 == 0) && acc < NE, rand_row(), 1'($urandom), 1'b1, ia, oa);
            if (ia) acc++;
        end
        n_cmp++;
        if (acc != NE || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bubbles_done: got acc %0d left %0d want %0d 0", acc, exp_q.size(), NE);
        end
    endtask

    task automatic test_back_to_back();
        logic ia, oa;
        int idx = 0;
        int pops = 0;
        int cycles = 0;
        while (pops < 3*NE && cycles < 200) begin
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %h want %h", cycles, dut_vec(), model_vec());
            end
            drive_and_tick(idx < 3*NE, rand_row(), 1'($urandom), 1'b1, ia, oa);
            if (ia) idx++;
            if (oa) pops++;
            cycles++;
        end
        n_cmp++;
        if (cycles != 6*NE || pops != 3*NE || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back_total: got cycles %0d pops %0d want %0d %0d", cycles, pops, 6*NE, 3*NE);
        end
    endtask

    task automatic test_random();
        logic ia, oa;
        int idx = 0;
        int pops = 0;
        int cycles = 0;
        while (pops < 4*NE && cycles < 1000) begin
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", cycles, dut_vec(), model_vec());
            end
            drive_and_tick(idx < 4*NE && $urandom_range(0, 2) != 0, rand_row(), 1'($urandom),
                           1'($urandom), ia, oa);
            if (ia) idx++;
            if (oa) pops++;
            cycles++;
        end
        n_cmp++;
        if (pops != 4*NE) begin
            n_fail++;
            $display("FAIL random_timeout: got pops %0d want %0d", pops, 4*NE);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic ia, oa;
        int idx = 0;
        int pops = 0;
        for (int i = 0; i < 40 && pops < 3; i++) begin
            drive_and_tick(idx < NE, rand_row(), 1'b1, 1'b1, ia, oa);
            if (ia) idx++;
            if (oa) pops++;
        end
        in_if.valid = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({in_if.ready, out_if.valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got rdy/vld/busy %b want 100", {in_if.ready, out_if.valid, busy});
        end
        model_reset();
        in_if.valid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        idx = 0;
        pops = 0;
        for (int i = 0; i < 40 && pops < NE; i++) begin
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL after_reset cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            drive_and_tick(idx < NE, rand_row(), 1'b1, 1'b1, ia, oa);
            if (ia) idx++;
            if (oa) pops++;
        end
        n_cmp++;
        if (pops != NE) begin
            n_fail++;
            $display("FAIL after_reset_pops: got %0d want %0d", pops, NE);
        end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_passthrough();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
